// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared types and constants for the LEGv8 multi-cycle control unit
package legv8_ctrl_pkg;

  // FSM states
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_ALU     = 3'd1,
    CLS_LDUR    = 3'd2,
    CLS_STUR    = 3'd3,
    CLS_CBZ     = 3'd4,
    CLS_CBNZ    = 3'd5,
    CLS_B       = 3'd6,
    CLS_BCOND   = 3'd7
  } instr_class_e;

  // Decoded fields latched at the end of DECODE
  typedef struct packed {
    instr_class_e cls;
    logic [4:0]   sa;
    logic [4:0]   sb;
    logic [4:0]   da;
    logic [4:0]   fs;
    logic         bsel;
    logic         set_flags;
    logic [3:0]   cond;
  } decode_t;

  // ALU function select: [4:2] op, [1] invert A, [0] invert B / carry-in
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  // 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // 10-bit opcodes
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  // 8-bit opcodes
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // 6-bit opcodes
  localparam logic [5:0]  OP_B     = 6'b000101;

  // Control word bit positions
  localparam int CW_EN_ALU   = 0;
  localparam int CW_EN_MEM   = 1;
  localparam int CW_BSEL     = 2;
  localparam int CW_FS_LSB   = 3;
  localparam int CW_MEMWRITE = 8;
  localparam int CW_REGWRITE = 9;
  localparam int CW_DA_LSB   = 10;
  localparam int CW_SB_LSB   = 15;
  localparam int CW_SA_LSB   = 20;

  // PC source select
  localparam logic [1:0] PC_SEL_INC    = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;

  // B.cond condition codes
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;

  // flags = {V, C, N, Z}; unsupported codes are never taken
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic v, c, n, z, r;
    {v, c, n, z} = flags;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_HI: r = c & ~z;
      COND_LS: r = ~(c & ~z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/legv8_instr_decode.sv
// rtl/legv8_instr_decode.sv - combinational IR to register fields, class and immediate
// Optional B.cond decode is enabled by LEGV8_BCOND_EN.
module legv8_instr_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [31:0]       ir_i,
  output decode_t           dec_o,
  output logic [ADDR_W-1:0] imm_o
);

  logic [4:0] rd, rn, rm;
  assign rd = ir_i[4:0];
  assign rn = ir_i[9:5];
  assign rm = ir_i[20:16];

  // Opcode match, widest field first, then per-class register routing
  always_comb begin
    dec_o     = '0;
    dec_o.cls = CLS_ILLEGAL;
    imm_o     = '0;

    case (ir_i[31:21])
      OP_ADD:  begin dec_o.cls = CLS_ALU; dec_o.fs = FS_ADD; end
      OP_ADDS: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_ADD; dec_o.set_flags = 1'b1; end
      OP_SUB:  begin dec_o.cls = CLS_ALU; dec_o.fs = FS_SUB; end
      OP_SUBS: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_SUB; dec_o.set_flags = 1'b1; end
      OP_AND:  begin dec_o.cls = CLS_ALU; dec_o.fs = FS_AND; end
      OP_ORR:  begin dec_o.cls = CLS_ALU; dec_o.fs = FS_ORR; end
      OP_EOR:  begin dec_o.cls = CLS_ALU; dec_o.fs = FS_EOR; end
      OP_LSL, OP_LSR: begin
        dec_o.cls  = CLS_ALU;
        dec_o.fs   = (ir_i[21]) ? FS_LSL : FS_LSR;
        dec_o.bsel = 1'b1;
        imm_o      = {{(ADDR_W-6){1'b0}}, ir_i[15:10]};
      end
      OP_LDUR, OP_STUR: begin
        dec_o.cls  = (ir_i[22]) ? CLS_LDUR : CLS_STUR;
        dec_o.fs   = FS_ADD;
        dec_o.bsel = 1'b1;
        imm_o      = {{(ADDR_W-9){ir_i[20]}}, ir_i[20:12]};
      end
      default: ;
    endcase

    if (dec_o.cls == CLS_ILLEGAL) begin
      case (ir_i[31:22])
        OP_ADDI: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_ADD; end
        OP_SUBI: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_SUB; end
        OP_ANDI: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_AND; end
        OP_ORRI: begin dec_o.cls = CLS_ALU; dec_o.fs = FS_ORR; end
        default: ;
      endcase
      if (dec_o.cls == CLS_ALU) begin
        dec_o.bsel = 1'b1;
        imm_o      = {{(ADDR_W-12){1'b0}}, ir_i[21:10]};
      end
    end

    if (dec_o.cls == CLS_ILLEGAL) begin
      case (ir_i[31:24])
        OP_CBZ:   dec_o.cls = CLS_CBZ;
        OP_CBNZ:  dec_o.cls = CLS_CBNZ;
`ifdef LEGV8_BCOND_EN
        OP_BCOND: dec_o.cls = CLS_BCOND;
`endif
        default: ;
      endcase
      if (dec_o.cls != CLS_ILLEGAL) begin
        dec_o.fs = FS_ADD;
        imm_o    = {{(ADDR_W-21){ir_i[23]}}, ir_i[23:5], 2'b00};
      end
    end

    if (dec_o.cls == CLS_ILLEGAL && ir_i[31:26] == OP_B) begin
      dec_o.cls = CLS_B;
      imm_o     = {{(ADDR_W-28){ir_i[25]}}, ir_i[25:0], 2'b00};
    end

    case (dec_o.cls)
      CLS_ALU: begin
        dec_o.sa = rn;
        dec_o.sb = dec_o.bsel ? 5'd0 : rm;
        dec_o.da = rd;
      end
      CLS_LDUR: begin dec_o.sa = rn; dec_o.da = rd; end
      CLS_STUR: begin dec_o.sa = rn; dec_o.sb = rd; end
      CLS_CBZ, CLS_CBNZ: begin dec_o.sa = rd; dec_o.sb = 5'd31; end
      CLS_BCOND: dec_o.cond = ir_i[3:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/legv8_control_fsm.sv
// rtl/legv8_control_fsm.sv - multi-cycle LEGv8 control FSM (FETCH/DECODE/EXECUTE/MEM/HALT)
// Optional B.cond support is enabled by LEGV8_BCOND_EN.
module legv8_control_fsm
  import legv8_ctrl_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic [4:0]        status,
  output logic [24:0]       ControlWord,
  output logic [ADDR_W-1:0] constant,
  output logic              SL,
  output logic              ir_load,
  output logic              pc_load,
  output logic [1:0]        pc_sel,
  output logic              halt,
  output logic [2:0]        state
);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  decode_t           dec_q, dec_d, dec_w;
  logic [ADDR_W-1:0] imm_q, imm_d, imm_w;
  logic              halt_q, halt_d;

  logic [4:0]        sa, sb, da, fs;
  logic              reg_write, mem_write, bsel, en_mem, en_alu;
  logic [ADDR_W-1:0] const_w;
  logic              sl_w, ir_ld_w, pc_ld_w;
  logic [1:0]        pc_sel_w;
  logic              cb_taken, bcond_taken;

  legv8_instr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .ir_i  (ir_q),
    .dec_o (dec_w),
    .imm_o (imm_w)
  );

  // State, instruction and decoded-field registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      dec_q   <= '0;
      imm_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      dec_q   <= dec_d;
      imm_q   <= imm_d;
      halt_q  <= halt_d;
    end
  end

  // CBZ/CBNZ look at the live zero flag, B.cond at the registered flags
  assign cb_taken    = (dec_q.cls == CLS_CBZ) ? status[0] : ~status[0];
  assign bcond_taken = cond_holds(dec_q.cond, status[4:1]);

  // Next-state and per-state control sequencing
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    dec_d     = dec_q;
    imm_d     = imm_q;
    halt_d    = halt_q;
    sa        = '0;
    sb        = '0;
    da        = '0;
    fs        = '0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    bsel      = 1'b0;
    en_mem    = 1'b0;
    en_alu    = 1'b0;
    const_w   = '0;
    sl_w      = 1'b0;
    ir_ld_w   = 1'b0;
    pc_ld_w   = 1'b0;
    pc_sel_w  = PC_SEL_INC;

    case (state_q)
      S_FETCH: begin
        ir_ld_w = 1'b1;
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_d = dec_w;
        imm_d = imm_w;
        if (dec_w.cls == CLS_ILLEGAL && HALT_ON_ILLEGAL != 0) begin
          state_d = S_HALT;
          halt_d  = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        pc_ld_w = 1'b1;
        case (dec_q.cls)
          CLS_ALU: begin
            sa        = dec_q.sa;
            sb        = dec_q.sb;
            da        = dec_q.da;
            fs        = dec_q.fs;
            bsel      = dec_q.bsel;
            const_w   = imm_q;
            en_alu    = 1'b1;
            reg_write = 1'b1;
            sl_w      = dec_q.set_flags;
          end
          CLS_LDUR: begin
            sa      = dec_q.sa;
            fs      = FS_ADD;
            bsel    = 1'b1;
            const_w = imm_q;
            pc_ld_w = 1'b0;
            state_d = S_MEM;
          end
          CLS_STUR: begin
            sa        = dec_q.sa;
            sb        = dec_q.sb;
            fs        = FS_ADD;
            bsel      = 1'b1;
            const_w   = imm_q;
            mem_write = 1'b1;
          end
          CLS_CBZ, CLS_CBNZ: begin
            sa       = dec_q.sa;
            sb       = dec_q.sb;
            fs       = FS_ADD;
            const_w  = imm_q;
            pc_sel_w = cb_taken ? PC_SEL_TARGET : PC_SEL_INC;
          end
          CLS_B: begin
            const_w  = imm_q;
            pc_sel_w = PC_SEL_TARGET;
          end
          CLS_BCOND: begin
            const_w  = imm_q;
            pc_sel_w = bcond_taken ? PC_SEL_TARGET : PC_SEL_INC;
          end
          default: ;  // illegal treated as NOP: just advance the PC
        endcase
      end
      S_MEM: begin
        sa        = dec_q.sa;
        da        = dec_q.da;
        fs        = FS_ADD;
        bsel      = 1'b1;
        const_w   = imm_q;
        en_mem    = 1'b1;
        reg_write = 1'b1;
        pc_ld_w   = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: halt_d = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe low in the same cycle so an abandoned instruction writes nothing
  always_comb begin
    ControlWord = '0;
    constant    = '0;
    SL          = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = PC_SEL_INC;
    if (!reset) begin
      ControlWord[CW_SA_LSB +: 5] = sa;
      ControlWord[CW_SB_LSB +: 5] = sb;
      ControlWord[CW_DA_LSB +: 5] = da;
      ControlWord[CW_REGWRITE]    = reg_write;
      ControlWord[CW_MEMWRITE]    = mem_write;
      ControlWord[CW_FS_LSB +: 5] = fs;
      ControlWord[CW_BSEL]        = bsel;
      ControlWord[CW_EN_MEM]      = en_mem;
      ControlWord[CW_EN_ALU]      = en_alu;
      constant = const_w;
      SL       = sl_w;
      ir_load  = ir_ld_w;
      pc_load  = pc_ld_w;
      pc_sel   = pc_sel_w;
    end
  end

  assign halt  = halt_q;
  assign state = state_q;

endmodule

// File: doc/legv8_control_fsm.md
Name: legv8_control_fsm

Overview:
- Multi-cycle control unit that drives the LEGv8 datapath's 25-bit control word, constant bus and program-counter controls.
- Latches the fetched instruction, decodes it, and sequences FETCH/DECODE/EXECUTE/MEM per instruction.
- Consumes the datapath's 5-bit status (registered flags plus live zero) to resolve conditional branches.

Parameters:
- ADDR_W, 64, width of the constant/offset bus
- HALT_ON_ILLEGAL, 1, 1 = an undecodable opcode enters HALT; 0 = it is treated as a NOP

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- instruction  input  32  instruction word from program ROM, valid in FETCH
- status  input  5  [4:1] = registered {V,C,N,Z}; [0] = live ALU zero
- ControlWord  output  25  {SA[4:0],SB[4:0],DA[4:0],RegWrite,MemWrite,FS[4:0],Bsel,EN_Mem,EN_ALU}
- constant  output  64  immediate, address offset or branch offset
- SL  output  1  status-register load enable
- ir_load  output  1  instruction latched this cycle
- pc_load  output  1  PC updates at the next edge
- pc_sel  output  2  00 = PC+4, 01 = PC+constant, 10/11 reserved
- halt  output  1  sticky stop indicator
- state  output  3  current FSM state (debug)

Behaviour:
- One clock; reset is synchronous and active-high. clock and reset are the only timing inputs.
- Reset: state=FETCH, IR=0, halt=0. While reset is high, ControlWord=0, constant=0, SL=0, pc_load=0, ir_load=0. Reset mid-instruction abandons it with no register or memory write.
- FETCH: ir_load=1; IR<=instruction; all write enables 0; next state DECODE.
- DECODE: fields extracted from IR into registered SA/SB/DA/FS/imm; no writes; next state EXECUTE, or HALT if illegal and HALT_ON_ILLEGAL=1.
- EXECUTE, R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS:
  - SA=Rn, SB=Rm, DA=Rd, Bsel=0, EN_ALU=1, RegWrite=1.
  - SL=1 only for ADDS/SUBS.
  - pc_load=1, pc_sel=00; next state FETCH.
- EXECUTE, I-type ADDI/SUBI/ANDI/ORRI:
  - Bsel=1, constant = zero-extended imm12.
  - Otherwise as R-type.
- EXECUTE, LSL/LSR: Bsel=1, constant = zero-extended shamt.
- EXECUTE, LDUR:
  - SA=Rn, Bsel=1, constant = sign-extended imm9, FS=ADD, no enables; next state MEM.
  - MEM: same SA/Bsel/constant/FS, DA=Rt, EN_Mem=1, RegWrite=1, pc_load=1; next state FETCH.
- EXECUTE, STUR: SA=Rn, SB=Rt, Bsel=1, constant=imm9, FS=ADD, MemWrite=1, pc_load=1; next state FETCH.
- EXECUTE, CBZ/CBNZ:
  - SA=Rt, SB=31 (XZR), Bsel=0, FS=ADD, constant = sign-extended imm19<<2.
  - pc_sel=01 if status[0]==1 (CBZ) or ==0 (CBNZ); else pc_sel=00.
  - pc_load=1. This output is Mealy on status[0].
- EXECUTE, B: constant = sign-extended imm26<<2, pc_sel=01, pc_load=1.
- FS encoding: FS[4:2] = op (AND 000, ORR 001, ADD 010, EOR 011, LSL 100, LSR 101); FS[1] = invert A; FS[0] = invert B/carry-in. SUB = 01001.
- Outputs other than CBZ/CBNZ/B.cond pc_sel are Moore (functions of state and IR only).
- Write enables are never asserted in FETCH, DECODE or HALT.
- HALT: all enables 0, halt=1, pc_load=0; leaves only on reset.
- Opcode match priority: 11-bit, then 10-bit, then 8-bit, then 6-bit fields.

Optional Feature:
- LEGV8_BCOND_EN defined:
  - B.cond (opcode 01010100) decoded.
  - EQ/NE/LT/GE/HI/LS/MI/PL evaluated from status[4:1].
  - Taken: pc_sel=01 with constant = imm19<<2.
- Undefined: B.cond is illegal and handled per HALT_ON_ILLEGAL.

Decomposition:
- Package legv8_ctrl_pkg holds:
  - state enum (FETCH=0, DECODE=1, EXECUTE=2, MEM=3, HALT=4);
  - FS constants;
  - opcode constants;
  - control-word field offsets;
  - pc_sel codes.
- One sub-module, legv8_instr_decode: combinational IR-to-fields/class/immediate decode. The FSM module owns the state register and output sequencing.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, state=FETCH, first ir_load=1 the cycle after release.
- instruction=0x8B020023 (ADD X3,X1,X2) -> EXECUTE ControlWord: SA=1, SB=2, DA=3, RegWrite=1, FS=01000, EN_ALU=1, pc_load=1, pc_sel=00; 3 cycles total.
- instruction=0xF8408025 (LDUR X5,[X1,#8]) -> EXECUTE constant=8, Bsel=1, no enables; MEM EN_Mem=1, RegWrite=1, DA=5; 4 cycles total.
- instruction=0xB4000064 (CBZ X4,+3) with status[0]=1 -> constant=12, pc_sel=01. Repeat with status[0]=0 -> pc_sel=00.
- instruction=0x00000000 with HALT_ON_ILLEGAL=1 -> halt=1 from the cycle after DECODE; no enables for 10 cycles; reset clears halt.
- Reset asserted during MEM of LDUR -> RegWrite and EN_Mem drop the same cycle; state=FETCH after release.
